extbus_bridge: RTL and testbench
================================

EXTBUS_BRIDGE -- requirements
Module: extbus_bridge

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for bus strobes (legal 2..3).
REQ-002 SHALL have ports: clk25 in 1, sole clock; rst_n in 1, asynchronous active-low reset.
REQ-003 SHALL have ports: extbus_cs_n, extbus_rd_n, extbus_wr_n in 1 each, raw asynchronous host strobes, active-low.
REQ-004 SHALL have ports: extbus_a in 5, host address; extbus_d_in in 8, host write data.
REQ-005 SHALL have ports: extbus_d_out out 8, read data to pad; extbus_d_oe out 1, pad output enable.
REQ-006 SHALL have ports: reg_addr out 5; reg_wdata out 8; reg_write out 1, one-cycle pulse; reg_read out 1, one-cycle pulse; reg_rdata in 8, valid the cycle after reg_read.
REQ-007 SHALL have port bus_err out 1, sticky flag for simultaneous rd/wr.

Function
REQ-008 SHALL pass cs_n, rd_n and wr_n each through SYNC_STAGES flops, reset value 1, before any use.
REQ-009 SHALL define rd_act = !cs_s & !rd_s & wr_s and wr_act = !cs_s & !wr_s & rd_s on the synchronized strobes.
REQ-010 SHALL implement FSM states IDLE, RD_REQ, RD_HOLD, WR_ACT, WR_COMMIT, encoded in the package.
REQ-011 SHALL, in IDLE with rd_act, capture extbus_a into reg_addr and go to RD_REQ.
REQ-012 SHALL, in RD_REQ, assert reg_read for exactly one cycle and go to RD_HOLD.
REQ-013 SHALL, on the first RD_HOLD cycle, latch reg_rdata into extbus_d_out and hold it until the next read latch.
REQ-014 SHALL stay in RD_HOLD while rd_act is high and return to IDLE the cycle after rd_act drops.
REQ-015 SHALL issue exactly one reg_read per host read strobe, however long the strobe lasts.
REQ-016 SHALL drive extbus_d_oe = !extbus_cs_n & !extbus_rd_n & extbus_wr_n combinationally from the raw pins.
REQ-017 SHALL, in IDLE with wr_act, go to WR_ACT.
REQ-018 SHALL, on every WR_ACT cycle, recapture extbus_a into reg_addr and extbus_d_in into reg_wdata.
REQ-019 SHALL, when wr_act drops in WR_ACT, go to WR_COMMIT and assert reg_write for exactly one cycle without recapturing, then return to IDLE.
REQ-020 SHALL, when cs_s deasserts mid-read or mid-write, end the cycle as if the strobe had ended; a write still commits.
REQ-021 SHALL, in IDLE with both !rd_s and !wr_s under !cs_s, set bus_err, issue no reg_read or reg_write, and stay in IDLE until both strobes are high.
REQ-022 SHALL require a host strobe low time of at least SYNC_STAGES+3 cycles and a high time of at least SYNC_STAGES+2 cycles; shorter strobes are out of contract.
REQ-023 SHALL never assert reg_read and reg_write in the same cycle.

Reset
REQ-024 SHALL, while rst_n is low, force FSM=IDLE, synchronizer flops=1, reg_addr=0, reg_wdata=0, extbus_d_out=0, reg_read=0, reg_write=0, bus_err=0.
REQ-025 SHALL, on reset mid-write, drop the write without a reg_write pulse.
REQ-026 SHALL clear bus_err only by reset.
REQ-027 SHALL release reset asynchronously; the first strobe is seen SYNC_STAGES cycles after its pins are stable.

Structure
REQ-028 SHALL place the FSM state enum and the REQ-022 minimum-timing constants in the shared vera package.
REQ-029 SHALL instantiate one sub-module, sync_ff (parameter STAGES, reset value 1), once per strobe.
REQ-030 SHALL keep the register file outside this block; the block only issues strobes.

Verification
REQ-031 Write: a=5'h0F, d=8'hA5, strobe low 8 cycles -> one reg_write pulse with reg_addr=0F and reg_wdata=A5, SYNC_STAGES+1 cycles after wr_n rises.
REQ-032 Read: reg_rdata model returns 8'h3C for addr 5'h03, rd_n low 10 cycles -> one reg_read pulse; extbus_d_out=3C from RD_HOLD; d_oe follows the raw pins.
REQ-033 Long read: rd_n low 40 cycles at addr 5'h03 -> exactly one reg_read pulse (read side effects fire once).
REQ-034 Conflict: rd_n and wr_n low together under cs_n=0 -> bus_err=1, no reg_read or reg_write pulses; a following legal write still commits.
REQ-035 Reset mid-write: rst_n low while WR_ACT -> no reg_write pulse; all outputs at REQ-024 values.
REQ-036 cs_n rises before wr_n with d=8'h77 -> one reg_write pulse with reg_wdata=77.

Source files
------------

// File: rtl/extbus_bridge_pkg.sv
// Shared definitions for the external host bus bridge.
// Contents:
//   state_t          - bridge FSM state encoding
//   MIN_LOW_EXTRA    - host strobe low time is at least SYNC_STAGES + MIN_LOW_EXTRA cycles
//   MIN_HIGH_EXTRA   - host strobe high time is at least SYNC_STAGES + MIN_HIGH_EXTRA cycles
//   min_low_cycles / min_high_cycles - helpers that fold in the synchronizer depth
package extbus_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_REQ    = 3'd1,
    RD_HOLD   = 3'd2,
    WR_ACT    = 3'd3,
    WR_COMMIT = 3'd4
  } state_t;

  localparam int unsigned MIN_LOW_EXTRA  = 3;
  localparam int unsigned MIN_HIGH_EXTRA = 2;

  function automatic int unsigned min_low_cycles(input int unsigned stages);
    return stages + MIN_LOW_EXTRA;
  endfunction

  function automatic int unsigned min_high_cycles(input int unsigned stages);
    return stages + MIN_HIGH_EXTRA;
  endfunction

endpackage

// File: rtl/extbus_bridge_sync_ff.sv
// Multi-flop synchronizer for one asynchronous, active-low host strobe.
// The chain resets to 1 so that a strobe reads as inactive during and after reset.
// Ports:
//   clk   - sampling clock
//   rst_n - asynchronous active-low reset
//   d     - raw asynchronous input
//   q     - synchronized output, STAGES cycles behind d
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_reg <= '1;
    end else begin
      chain_reg <= {chain_reg[STAGES-2:0], d};
    end
  end

  assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/extbus_bridge.sv
// Bridge from an asynchronous, strobe-based host bus to single-cycle register
// file strobes. Host strobes are synchronized, decoded into read/write
// activity, and turned into exactly one reg_read or reg_write pulse per
// host access. The register file itself lives outside this block.
// Ports:
//   clk25, rst_n                        - sole clock, asynchronous active-low reset
//   extbus_cs_n/rd_n/wr_n               - raw asynchronous host strobes (active-low)
//   extbus_a, extbus_d_in               - host address / write data
//   extbus_d_out, extbus_d_oe           - read data and output enable toward the pad
//   reg_addr, reg_wdata                 - register file address / write data
//   reg_write, reg_read                 - one-cycle register file strobes
//   reg_rdata                           - register read data, valid the cycle after reg_read
//   bus_err                             - sticky: host drove rd and wr together
module extbus_bridge
  import extbus_bridge_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk25,
  input  logic       rst_n,
  input  logic       extbus_cs_n,
  input  logic       extbus_rd_n,
  input  logic       extbus_wr_n,
  input  logic [4:0] extbus_a,
  input  logic [7:0] extbus_d_in,
  output logic [7:0] extbus_d_out,
  output logic       extbus_d_oe,
  output logic [4:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_write,
  output logic       reg_read,
  input  logic [7:0] reg_rdata,
  output logic       bus_err
);

  // Strobe order in the vectors: [2]=cs, [1]=rd, [0]=wr.
  logic [2:0] raw_strobes;
  logic [2:0] sync_strobes;

  assign raw_strobes = {extbus_cs_n, extbus_rd_n, extbus_wr_n};

  for (genvar gi = 0; gi < 3; gi++) begin : g_sync
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk25),
      .rst_n(rst_n),
      .d    (raw_strobes[gi]),
      .q    (sync_strobes[gi])
    );
  end

  logic cs_s, rd_s, wr_s;
  logic rd_act, wr_act;

  assign cs_s   = sync_strobes[2];
  assign rd_s   = sync_strobes[1];
  assign wr_s   = sync_strobes[0];
  assign rd_act = !cs_s && !rd_s && wr_s;
  assign wr_act = !cs_s && !wr_s && rd_s;

  // The pad enable must track the host immediately, so it bypasses the synchronizers.
  assign extbus_d_oe = !extbus_cs_n && !extbus_rd_n && extbus_wr_n;

  state_t state_reg;
  logic   err_lock_reg;  // set after a rd/wr conflict; held until both strobes release
  logic   rd_first_reg;  // marks the first RD_HOLD cycle, when reg_rdata is valid

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      err_lock_reg <= 1'b0;
      rd_first_reg <= 1'b0;
      reg_addr     <= '0;
      reg_wdata    <= '0;
      extbus_d_out <= '0;
      reg_read     <= 1'b0;
      reg_write    <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      // Strobes default low so each assertion below lasts exactly one cycle.
      reg_read  <= 1'b0;
      reg_write <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (err_lock_reg) begin
            if (rd_s && wr_s) err_lock_reg <= 1'b0;
          end else if (!cs_s && !rd_s && !wr_s) begin
            bus_err      <= 1'b1;
            err_lock_reg <= 1'b1;
          end else if (rd_act) begin
            reg_addr  <= extbus_a;
            reg_read  <= 1'b1;
            state_reg <= RD_REQ;
          end else if (wr_act) begin
            state_reg <= WR_ACT;
          end
        end
        RD_REQ: begin
          rd_first_reg <= 1'b1;
          state_reg    <= RD_HOLD;
        end
        RD_HOLD: begin
          rd_first_reg <= 1'b0;
          if (rd_first_reg) extbus_d_out <= reg_rdata;
          if (!rd_act) state_reg <= IDLE;
        end
        WR_ACT: begin
          if (wr_act) begin
            reg_addr  <= extbus_a;
            reg_wdata <= extbus_d_in;
          end else begin
            // Strobe or chip select released: commit what was last captured.
            reg_write <= 1'b1;
            state_reg <= WR_COMMIT;
          end
        end
        WR_COMMIT: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_extbus_bridge.sv
module tb_extbus_bridge;

  localparam int S = 2;

  logic       clk25 = 1'b0;
  logic       rst_n;
  logic       extbus_cs_n, extbus_rd_n, extbus_wr_n;
  logic [4:0] extbus_a;
  logic [7:0] extbus_d_in;
  logic [7:0] extbus_d_out;
  logic       extbus_d_oe;
  logic [4:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_write, reg_read;
  logic [7:0] reg_rdata;
  logic       bus_err;

  int n_cmp = 0;
  int n_err = 0;

  int cyc = 0;
  int rd_pulses = 0;
  int wr_pulses = 0;
  int both_pulses = 0;
  int wr_cyc = 0;
  int rise_cyc = 0;
  logic [4:0] last_wr_addr = '0;
  logic [7:0] last_wdata = '0;

  always #20 clk25 = ~clk25;

  extbus_bridge #(.SYNC_STAGES(S)) dut (
    .clk25       (clk25),
    .rst_n       (rst_n),
    .extbus_cs_n (extbus_cs_n),
    .extbus_rd_n (extbus_rd_n),
    .extbus_wr_n (extbus_wr_n),
    .extbus_a    (extbus_a),
    .extbus_d_in (extbus_d_in),
    .extbus_d_out(extbus_d_out),
    .extbus_d_oe (extbus_d_oe),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_write   (reg_write),
    .reg_read    (reg_read),
    .reg_rdata   (reg_rdata),
    .bus_err     (bus_err)
  );

  // Register file model: fixed contents, read data one cycle after reg_read.
  function automatic logic [7:0] model_rd(input logic [4:0] addr);
    case (addr)
      5'h03:   return 8'h3C;
      5'h11:   return 8'h5A;
      default: return {3'b000, addr};
    endcase
  endfunction

  always @(posedge clk25) begin
    cyc <= cyc + 1;
    if (reg_read) reg_rdata <= model_rd(reg_addr);
  end

  // Pulse monitor, sampled mid-cycle.
  always @(negedge clk25) begin
    if (reg_read) rd_pulses++;
    if (reg_write) begin
      wr_pulses++;
      last_wr_addr = reg_addr;
      last_wdata   = reg_wdata;
      wr_cyc       = cyc;
    end
    if (reg_read && reg_write) both_pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic host_write(input logic [4:0] a, input logic [7:0] d, input int low, input bit cs_first);
    @(negedge clk25);
    extbus_a    = a;
    extbus_d_in = d;
    extbus_cs_n = 1'b0;
    extbus_wr_n = 1'b0;
    repeat (low) @(negedge clk25);
    if (cs_first) begin
      extbus_cs_n = 1'b1;
      @(negedge clk25);
      extbus_wr_n = 1'b1;
    end else begin
      extbus_wr_n = 1'b1;
      extbus_cs_n = 1'b1;
    end
    rise_cyc = cyc;
    repeat (8) @(negedge clk25);
    $display("write a=%0h d=%0h low=%0d cs_first=%0d -> wr_pulses=%0d", a, d, low, cs_first, wr_pulses);
  endtask

  task automatic host_read(input logic [4:0] a, input int low);
    @(negedge clk25);
    extbus_a    = a;
    extbus_cs_n = 1'b0;
    extbus_rd_n = 1'b0;
    #1 chk("d_oe_during_read", extbus_d_oe, 1'b1);
    repeat (low) @(negedge clk25);
    extbus_rd_n = 1'b1;
    extbus_cs_n = 1'b1;
    #1 chk("d_oe_after_read", extbus_d_oe, 1'b0);
    repeat (8) @(negedge clk25);
    $display("read a=%0h low=%0d -> d_out=%0h rd_pulses=%0d", a, low, extbus_d_out, rd_pulses);
  endtask

  initial begin
    int rp, wp;
    rst_n       = 1'b0;
    extbus_cs_n = 1'b1;
    extbus_rd_n = 1'b1;
    extbus_wr_n = 1'b1;
    extbus_a    = '0;
    extbus_d_in = '0;
    repeat (3) @(negedge clk25);
    chk("rst_reg_addr", reg_addr, 5'h00);
    chk("rst_d_out", extbus_d_out, 8'h00);
    chk("rst_bus_err", bus_err, 1'b0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk25);

    // Basic write with timing check.
    host_write(5'h0F, 8'hA5, 8, 1'b0);
    chk("wr_count", wr_pulses, 1);
    chk("wr_addr", last_wr_addr, 5'h0F);
    chk("wr_data", last_wdata, 8'hA5);
    chk("wr_latency", wr_cyc - rise_cyc, S + 1);

    // Basic read.
    host_read(5'h03, 10);
    chk("rd_count", rd_pulses, 1);
    chk("rd_data", extbus_d_out, 8'h3C);
    chk("rd_addr", reg_addr, 5'h03);

    // Long read issues a single reg_read.
    host_read(5'h03, 40);
    chk("long_rd_count", rd_pulses, 2);

    // Read of a different register updates the pad data.
    host_read(5'h11, 7);
    chk("rd2_data", extbus_d_out, 8'h5A);
    chk("rd2_count", rd_pulses, 3);

    // Chip select released before the write strobe.
    host_write(5'h07, 8'h77, 7, 1'b1);
    chk("csfirst_count", wr_pulses, 2);
    chk("csfirst_data", last_wdata, 8'h77);

    // Conflict: rd and wr low together.
    rp = rd_pulses;
    wp = wr_pulses;
    @(negedge clk25);
    extbus_a    = 5'h02;
    extbus_cs_n = 1'b0;
    extbus_rd_n = 1'b0;
    extbus_wr_n = 1'b0;
    #1 chk("conflict_d_oe", extbus_d_oe, 1'b0);
    repeat (8) @(negedge clk25);
    extbus_rd_n = 1'b1;
    extbus_wr_n = 1'b1;
    extbus_cs_n = 1'b1;
    repeat (8) @(negedge clk25);
    $display("conflict -> bus_err=%0d", bus_err);
    chk("conflict_bus_err", bus_err, 1'b1);
    chk("conflict_no_rd", rd_pulses, rp);
    chk("conflict_no_wr", wr_pulses, wp);
    host_write(5'h1A, 8'hC3, 6, 1'b0);
    chk("post_conflict_wr", wr_pulses, wp + 1);
    chk("post_conflict_data", last_wdata, 8'hC3);
    chk("bus_err_sticky", bus_err, 1'b1);

    // Reset in the middle of a write.
    wp = wr_pulses;
    @(negedge clk25);
    extbus_a    = 5'h1F;
    extbus_d_in = 8'hFF;
    extbus_cs_n = 1'b0;
    extbus_wr_n = 1'b0;
    repeat (6) @(negedge clk25);
    chk("midwr_captured", reg_addr, 5'h1F);
    rst_n       = 1'b0;
    extbus_wr_n = 1'b1;
    extbus_cs_n = 1'b1;
    #1;
    chk("midrst_reg_addr", reg_addr, 5'h00);
    chk("midrst_wdata", reg_wdata, 8'h00);
    chk("midrst_d_out", extbus_d_out, 8'h00);
    chk("midrst_read", reg_read, 1'b0);
    chk("midrst_write", reg_write, 1'b0);
    chk("midrst_bus_err", bus_err, 1'b0);
    repeat (2) @(negedge clk25);
    rst_n = 1'b1;
    repeat (10) @(negedge clk25);
    $display("reset mid-write -> wr_pulses=%0d", wr_pulses);
    chk("midrst_no_wr", wr_pulses, wp);

    chk("never_both", both_pulses, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
